// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO register slave: register offsets, reset value, bus FSM states.
package gpio_pkg;

    localparam int unsigned GPIO_DIR     = 0;
    localparam int unsigned GPIO_OUT     = 1;
    localparam int unsigned GPIO_IN      = 2;
    localparam int unsigned GPIO_IE      = 3;
    localparam int unsigned GPIO_POL     = 4;
    localparam int unsigned GPIO_ISR     = 5;
    localparam int unsigned GPIO_OUT_SET = 6;
    localparam int unsigned GPIO_OUT_CLR = 7;

    localparam logic [7:0] GPIO_RST_VAL = 8'h00;

    typedef enum logic {
        StIdle,
        StAck
    } bus_state_e;

endpackage

// File: rtl/gpio_sync.sv
// Input synchroniser for the GPIO read-back byte with a prev stage, warm-up gate and
// polarity-qualified edge detection.
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] port_in,
    input  logic [DATA_W-1:0] pol,
    output logic [DATA_W-1:0] in_sync,
    output logic [DATA_W-1:0] edge_vec
);

    // Warm-up length is SYNC_STAGES+1, saturated to what the 2-bit counter can hold.
    localparam int unsigned WarmLen  = (SYNC_STAGES + 1 > 3) ? 3 : SYNC_STAGES + 1;
    localparam logic [1:0]  WarmDone = 2'(WarmLen);

    logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q, sync_d;
    logic [DATA_W-1:0]                  prev_q, prev_d;
    logic [1:0]                         warm_q, warm_d;
    logic [DATA_W-1:0]                  rise, fall;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = port_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        in_sync  = sync_q[SYNC_STAGES-1];
        prev_d   = in_sync;
        warm_d   = (warm_q == WarmDone) ? warm_q : warm_q + 2'd1;
        rise     = in_sync & ~prev_q;
        fall     = ~in_sync & prev_q;
        edge_vec = (warm_q == WarmDone) ? ((rise & ~pol) | (fall & pol)) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
            warm_q <= 2'd0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            warm_q <= warm_d;
        end
    end

endmodule

// File: rtl/gpio_regs.sv
// GPIO register slave: bus FSM, direction/output/IE/POL registers, sticky edge status
// with write-1-to-clear, read mux and registered level interrupt.
module gpio_regs
    import gpio_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_sel,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_ack,
    output logic [DATA_W-1:0] port_dir,
    output logic [DATA_W-1:0] port_out,
    input  logic [DATA_W-1:0] port_in,
    output logic              irq
);

    localparam logic [DATA_W-1:0] RstVal = DATA_W'(GPIO_RST_VAL);

    bus_state_e        state_q, state_d;
    logic [DATA_W-1:0] dir_q, dir_d, out_q, out_d, ie_q, ie_d, pol_q, pol_d;
    logic [DATA_W-1:0] isr_q, isr_d, rdata_q, rdata_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] in_sync, edge_vec, rd_val;
    logic [31:0]       addr_idx;

    gpio_sync #(
        .DATA_W     (DATA_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .port_in (port_in),
        .pol     (pol_q),
        .in_sync (in_sync),
        .edge_vec(edge_vec)
    );

    always_comb begin
        addr_idx = 32'(bus_addr);
        case (addr_idx)
            GPIO_DIR: rd_val = dir_q;
            GPIO_OUT: rd_val = out_q;
            GPIO_IN:  rd_val = in_sync;
            GPIO_IE:  rd_val = ie_q;
            GPIO_POL: rd_val = pol_q;
            GPIO_ISR: rd_val = isr_q;
            default:  rd_val = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rdata_d = '0;
        dir_d   = dir_q;
        out_d   = out_q;
        ie_d    = ie_q;
        pol_d   = pol_q;
        isr_d   = isr_q;
        unique case (state_q)
            StIdle: begin
                if (bus_sel) begin
                    state_d = StAck;
                    if (bus_we) begin
                        case (addr_idx)
                            GPIO_DIR:     dir_d = bus_wdata;
                            GPIO_OUT:     out_d = bus_wdata;
                            GPIO_IE:      ie_d  = bus_wdata;
                            GPIO_POL:     pol_d = bus_wdata;
                            GPIO_ISR:     isr_d = isr_q & ~bus_wdata;
                            GPIO_OUT_SET: out_d = out_q | bus_wdata;
                            GPIO_OUT_CLR: out_d = out_q & ~bus_wdata;
                            default:      ;
                        endcase
                    end else begin
                        rdata_d = rd_val;
                    end
                end
            end
            StAck: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Applied after the W1C so a coincident edge is never lost.
        isr_d = isr_d | edge_vec;
        irq_d = |(isr_q & ie_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rdata_q <= '0;
            dir_q   <= RstVal;
            out_q   <= RstVal;
            ie_q    <= RstVal;
            pol_q   <= RstVal;
            isr_q   <= RstVal;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            dir_q   <= dir_d;
            out_q   <= out_d;
            ie_q    <= ie_d;
            pol_q   <= pol_d;
            isr_q   <= isr_d;
            irq_q   <= irq_d;
        end
    end

    assign bus_ack   = (state_q == StAck);
    assign bus_rdata = rdata_q;
    assign port_dir  = dir_q;
    assign port_out  = out_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_regs.sv
// Directed self-checking bench for gpio_regs with hand-computed expectations.
module tb_gpio_regs;

    logic       clk = 1'b0;
    logic       rst;
    logic       bus_sel, bus_we;
    logic [2:0] bus_addr;
    logic [7:0] bus_wdata, bus_rdata;
    logic       bus_ack;
    logic [7:0] port_dir, port_out, port_in;
    logic       irq;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] rd;

    gpio_regs #(
        .DATA_W     (8),
        .ADDR_W     (3),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_sel  (bus_sel),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .port_dir (port_dir),
        .port_out (port_out),
        .port_in  (port_in),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_xfer(input logic we, input logic [2:0] addr, input logic [7:0] wdata,
                            output logic [7:0] rdata);
        logic got;
        got = 1'b0;
        @(negedge clk);
        bus_sel = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus_ack) got = 1'b1;
        end
        rdata = bus_rdata;
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus_sel = 1'b0; bus_we = 1'b0;
    endtask

    task automatic bus_wr(input logic [2:0] addr, input logic [7:0] data);
        logic [7:0] dummy;
        bus_xfer(1'b1, addr, data, dummy);
    endtask

    task automatic bus_rd(input logic [2:0] addr, output logic [7:0] data);
        bus_xfer(1'b0, addr, 8'h00, data);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
    endtask

    logic [2:0] b2b_addr [5] = '{3'd0, 3'd1, 3'd6, 3'd3, 3'd4};
    logic [7:0] b2b_exp  [5] = '{8'h0F, 8'h0C, 8'h00, 8'h10, 8'h01};

    initial begin
        rst = 1'b1; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        port_in = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(bus_ack), 32'd0);
        check("rst_dir", 32'(port_dir), 32'h00);
        rst = 1'b0;
        settle(5);

        // Register writes, set/clear aliases.
        bus_wr(3'd0, 8'h0F);
        check("dir_wr", 32'(port_dir), 32'h0F);
        bus_wr(3'd1, 8'h05);
        check("out_wr", 32'(port_out), 32'h05);
        bus_wr(3'd6, 8'h0A);
        check("out_set", 32'(port_out), 32'h0F);
        bus_rd(3'd1, rd);
        check("out_rd", 32'(rd), 32'h0F);
        bus_wr(3'd7, 8'h03);
        check("out_clr", 32'(port_out), 32'h0C);
        bus_wr(3'd2, 8'hAA);
        bus_rd(3'd2, rd);
        check("in_ro", 32'(rd), 32'h00);

        // Rising edge on bit 4, sync latency and irq timing.
        bus_wr(3'd4, 8'h00);
        bus_wr(3'd3, 8'h10);
        @(negedge clk); port_in = 8'h10;
        settle(3); #1;
        check("irq_e3", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check("irq_e4", 32'(irq), 32'd1);
        bus_rd(3'd2, rd);
        check("in_rd", 32'(rd), 32'h10);
        bus_rd(3'd5, rd);
        check("isr_set", 32'(rd), 32'h10);
        bus_wr(3'd5, 8'h00);
        bus_rd(3'd5, rd);
        check("isr_w0", 32'(rd), 32'h10);
        bus_wr(3'd5, 8'h10);
        bus_rd(3'd5, rd);
        check("isr_w1c", 32'(rd), 32'h00);
        check("irq_clr", 32'(irq), 32'd0);

        // Falling edge ignored with POL=0; then W1C colliding with a new edge.
        @(negedge clk); port_in = 8'h00;
        settle(5);
        bus_rd(3'd5, rd);
        check("no_fall", 32'(rd), 32'h00);
        @(negedge clk); port_in = 8'h10;
        settle(5);
        bus_rd(3'd5, rd);
        check("isr_set2", 32'(rd), 32'h10);
        @(negedge clk); port_in = 8'h00;
        settle(5);
        @(negedge clk); port_in = 8'h10;
        @(posedge clk); @(posedge clk);
        bus_wr(3'd5, 8'h10);
        bus_rd(3'd5, rd);
        check("w1c_vs_set", 32'(rd), 32'h10);
        bus_wr(3'd5, 8'h10);
        bus_rd(3'd5, rd);
        check("isr_clr2", 32'(rd), 32'h00);

        // Falling polarity on bit 0; IE masks it from irq.
        bus_wr(3'd4, 8'h01);
        bus_rd(3'd5, rd);
        check("pol_change", 32'(rd), 32'h00);
        @(negedge clk); port_in = 8'h11;
        settle(5);
        bus_rd(3'd5, rd);
        check("pol_rise_ign", 32'(rd), 32'h00);
        @(negedge clk); port_in = 8'h10;
        settle(5);
        bus_rd(3'd5, rd);
        check("pol_fall", 32'(rd), 32'h01);
        check("ie_mask", 32'(irq), 32'd0);
        bus_wr(3'd5, 8'h01);

        // Back-to-back reads with bus_sel held high.
        @(negedge clk);
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = b2b_addr[0];
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("b2b_ack", 32'(bus_ack), 32'd1);
            check("b2b_rdata", 32'(bus_rdata), 32'(b2b_exp[k]));
            @(negedge clk);
            if (k < 4) bus_addr = b2b_addr[k+1];
            else bus_sel = 1'b0;
            @(posedge clk); #1;
            check("b2b_gap_ack", 32'(bus_ack), 32'd0);
            check("b2b_gap_rdata", 32'(bus_rdata), 32'd0);
        end

        // Reset mid-transaction, pins high through reset release.
        bus_wr(3'd3, 8'hF0);
        @(negedge clk); port_in = 8'hF0;
        settle(5); #1;
        check("pre_rst_irq", 32'(irq), 32'd1);
        @(negedge clk);
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 3'd0;
        @(posedge clk); #1;
        check("mid_ack", 32'(bus_ack), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_ack", 32'(bus_ack), 32'd0);
        check("rst_mid_rdata", 32'(bus_rdata), 32'd0);
        check("rst_mid_dir", 32'(port_dir), 32'h00);
        check("rst_mid_out", 32'(port_out), 32'h00);
        check("rst_mid_irq", 32'(irq), 32'd0);
        @(negedge clk); bus_sel = 1'b0;
        @(negedge clk); rst = 1'b0;
        settle(6);
        bus_rd(3'd0, rd); check("rb_dir", 32'(rd), 32'h00);
        bus_rd(3'd1, rd); check("rb_out", 32'(rd), 32'h00);
        bus_rd(3'd3, rd); check("rb_ie", 32'(rd), 32'h00);
        bus_rd(3'd4, rd); check("rb_pol", 32'(rd), 32'h00);
        bus_rd(3'd5, rd); check("warm_isr", 32'(rd), 32'h00);
        bus_rd(3'd2, rd); check("warm_in", 32'(rd), 32'hF0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
